chiplet_compute_scheduler: RTL

//  Sequences one chiplet compute stage. Joins num_in_p valid/ready input streams of {id, size} workload

---
 rtl/chiplet_compute_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/chiplet_compute_scheduler.sv
// chiplet_compute_scheduler
//   Sequences one chiplet compute stage. Joins num_in_p valid/ready streams of {id, size}
//   workload descriptors, derives the MAC cycle count of the joined workload, stays busy for
//   exactly that many cycles and then presents the joined descriptor downstream. One workload
//   is in flight at a time.
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   v_i            per-input descriptor valid
//   data_i         per-input {id, size}, input k at [k*width_p +: width_p]
//   ready_o        per-input ready, all bits equal (join)
//   v_o            output descriptor valid
//   data_o         {id of input 0, computed size}
//   ready_i        downstream ready
//   busy_o         stage is in COMPUTE
//   err_o          sticky id-mismatch / size-sum overflow flag
//   busy_cycles_o  saturating count of cycles spent in COMPUTE

module chiplet_compute_scheduler #(
  parameter int id_width_p      = 4,
  parameter int size_width_p    = 8,
  parameter int num_in_p        = 2,
  parameter int num_macs_p      = 1,
  parameter int inputs_select_p = -1,
  parameter int macs_per_data_p = 1,
  parameter int width_p         = id_width_p + size_width_p,
  parameter int cycles_width_p  = size_width_p + $clog2(macs_per_data_p) + 1,
  parameter int stat_width_p    = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_in_p-1:0]          v_i,
  input  logic [num_in_p*width_p-1:0]  data_i,
  output logic [num_in_p-1:0]          ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [stat_width_p-1:0]      busy_cycles_o
);

  // Elaboration-time parameter checks.
  if (inputs_select_p < -1 || inputs_select_p >= num_in_p) begin : g_bad_select
    $error("inputs_select_p out of range");
  end
  if (num_in_p < 1 || num_macs_p < 1 || macs_per_data_p < 1) begin : g_bad_counts
    $error("num_in_p, num_macs_p and macs_per_data_p must be >= 1");
  end

  localparam int SumWidth = size_width_p + $clog2(num_in_p) + 1;
  localparam int DivWidth = (cycles_width_p > 32) ? cycles_width_p : 32;

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e                    state_q, state_d;
  logic [cycles_width_p-1:0] counter_q, counter_d;
  logic [width_p-1:0]        data_q, data_d;
  logic                      v_q, v_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic [stat_width_p-1:0]   busy_cycles_q, busy_cycles_d;

  logic                      join_hs;
  logic                      id_mismatch;
  logic                      size_ovf;
  logic [size_width_p-1:0]   join_size;
  logic [id_width_p-1:0]     id0;
  logic [DivWidth-1:0]       prod;
  logic [cycles_width_p-1:0] cycles;

  assign id0 = data_i[size_width_p +: id_width_p];

  // Join: nothing is consumed until every input is valid, and only while idle.
  assign join_hs = (state_q == StIdle) && (&v_i);
  assign ready_o = {num_in_p{join_hs}};

  always_comb begin
    id_mismatch = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      if (data_i[i*width_p+size_width_p +: id_width_p] != id0) id_mismatch = 1'b1;
    end
  end

  if (inputs_select_p < 0) begin : g_gather
    logic [SumWidth-1:0] sum_full;
    always_comb begin
      sum_full = '0;
      for (int i = 0; i < num_in_p; i++) begin
        sum_full = sum_full + SumWidth'(data_i[i*width_p +: size_width_p]);
      end
    end
    // Any carry out of the running modular sum shows up as a nonzero upper bit.
    assign join_size = sum_full[size_width_p-1:0];
    assign size_ovf  = |sum_full[SumWidth-1:size_width_p];
  end else begin : g_select
    logic unused_data;
    assign unused_data = ^data_i;
    assign join_size   = data_i[inputs_select_p*width_p +: size_width_p];
    assign size_ovf    = 1'b0;
  end

  // Full-width product, truncating divide.
  assign prod   = DivWidth'(join_size) * DivWidth'(macs_per_data_p);
  assign cycles = cycles_width_p'(prod / DivWidth'(num_macs_p));

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    data_d        = data_q;
    v_d           = v_q;
    busy_d        = busy_q;
    err_d         = err_q;
    busy_cycles_d = busy_cycles_q;
    unique case (state_q)
      StIdle: begin
        if (join_hs) begin
          data_d = {id0, join_size};
          err_d  = err_q | id_mismatch | size_ovf;
          if (cycles != '0) begin
            state_d   = StCompute;
            counter_d = cycles;
            busy_d    = 1'b1;
          end else begin
            state_d = StOutput;
            v_d     = 1'b1;
          end
        end
      end
      StCompute: begin
        counter_d = counter_q - cycles_width_p'(1);
        if (busy_cycles_q != '1) busy_cycles_d = busy_cycles_q + stat_width_p'(1);
        if (counter_q == cycles_width_p'(1)) begin
          state_d = StOutput;
          busy_d  = 1'b0;
          v_d     = 1'b1;
        end
      end
      StOutput: begin
        if (ready_i) begin
          state_d = StIdle;
          v_d     = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        v_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      counter_q     <= '0;
      data_q        <= '0;
      v_q           <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      data_q        <= data_d;
      v_q           <= v_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign v_o           = v_q;
  assign data_o        = data_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign busy_cycles_o = busy_cycles_q;

endmodule
